mem_wb_stage: RTL

Parametrised MEM→WB pipeline stage for the RISC-V core, and the successor of the fixed 32-bit MEM/WB register. It carries the memory-stage fields to writeback under a valid/ready handshake, with an optional skid entry, a synchronous flush, and the writeback result mux. It sits between the data-memory stage and the register file write port, so a stalled writeback never drops an instruction or loses throughput.

---
 rtl/riscv_pkg.sv | 17 +
 rtl/pipe_skid_buf.sv | 140 ++++++++++++++
 rtl/mem_wb_stage.sv | 73 +++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared core package: datapath width default, writeback
// source encodings and the elastic-buffer state type.
package riscv_pkg;

    localparam int DEFAULT_XLEN = 32;

    localparam logic [1:0] RESULT_ALU = 2'b00;
    localparam logic [1:0] RESULT_MEM = 2'b01;
    localparam logic [1:0] RESULT_PC4 = 2'b10;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'b00,
        BUF_FULL  = 2'b01,
        BUF_SKID  = 2'b10
    } buf_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready pipeline register, optionally with a skid entry.
// Ports: clock, reset, flush, in_valid/in_ready/in_data, out_valid/out_ready/out_data.
import riscv_pkg::*;

module pipe_skid_buf #(
    parameter int WIDTH = 8,
    parameter bit SKID  = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    generate
        if (SKID) begin : g_skid
            buf_state_e       state_q;
            buf_state_e       state_d;
            logic [WIDTH-1:0] main_q;
            logic [WIDTH-1:0] skid_q;
            logic             ready_q;
            logic             accept;
            logic             drain;
            logic             load_main;
            logic             load_skid;
            logic             move_skid;

            assign accept    = in_valid && ready_q;
            assign drain     = out_valid && out_ready;
            assign out_valid = (state_q != BUF_EMPTY);
            assign in_ready  = ready_q;
            assign out_data  = main_q;

            always_comb begin
                state_d   = state_q;
                load_main = 1'b0;
                load_skid = 1'b0;
                move_skid = 1'b0;
                if (flush) begin
                    state_d = BUF_EMPTY;
                end else begin
                    unique case (state_q)
                        BUF_EMPTY: begin
                            if (accept) begin
                                state_d   = BUF_FULL;
                                load_main = 1'b1;
                            end
                        end
                        BUF_FULL: begin
                            if (accept && !drain) begin
                                state_d   = BUF_SKID;
                                load_skid = 1'b1;
                            end else if (drain && !accept) begin
                                state_d = BUF_EMPTY;
                            end else if (accept && drain) begin
                                load_main = 1'b1;
                            end
                        end
                        BUF_SKID: begin
                            if (drain) begin
                                state_d   = BUF_FULL;
                                move_skid = 1'b1;
                            end
                        end
                        default: state_d = BUF_EMPTY;
                    endcase
                end
            end

            // in_ready is registered: it reflects whether the skid
            // entry will be free after this edge.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    state_q <= BUF_EMPTY;
                    ready_q <= 1'b1;
                end else begin
                    state_q <= state_d;
                    ready_q <= (state_d != BUF_SKID);
                end
            end

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    main_q <= '0;
                    skid_q <= '0;
                end else begin
                    if (load_main) begin
                        main_q <= in_data;
                    end else if (move_skid) begin
                        main_q <= skid_q;
                    end
                    if (load_skid) begin
                        skid_q <= in_data;
                    end
                end
            end
        end else begin : g_reg
            logic             valid_q;
            logic             valid_d;
            logic [WIDTH-1:0] main_q;
            logic             accept;
            logic             drain;

            assign in_ready  = !valid_q || out_ready;
            assign accept    = in_valid && in_ready;
            assign drain     = valid_q && out_ready;
            assign out_valid = valid_q;
            assign out_data  = main_q;

            always_comb begin
                valid_d = valid_q;
                if (flush) begin
                    valid_d = 1'b0;
                end else if (accept) begin
                    valid_d = 1'b1;
                end else if (drain) begin
                    valid_d = 1'b0;
                end
            end

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    valid_q <= 1'b0;
                    main_q  <= '0;
                end else begin
                    valid_q <= valid_d;
                    if (accept && !flush) begin
                        main_q <= in_data;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline stage: elastic field transport, rd!=0 write
// qualification and writeback result mux. Ports: clock, reset, flush,
// in_valid/in_ready + *_m fields, out_valid/out_ready + *_w fields.
import riscv_pkg::*;

module mem_wb_stage #(
    parameter int XLEN   = DEFAULT_XLEN,
    parameter int REG_AW = 5,
    parameter bit SKID   = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   alu_result_m,
    input  logic [XLEN-1:0]   read_data_m,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [XLEN-1:0]   pc_plus4_m,
    input  logic              reg_write_m,
    input  logic [1:0]        result_src_m,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   alu_result_w,
    output logic [XLEN-1:0]   read_data_w,
    output logic [XLEN-1:0]   pc_plus4_w,
    output logic [REG_AW-1:0] rd_w,
    output logic              reg_write_w,
    output logic [XLEN-1:0]   result_w
);

    localparam int W = 3 + REG_AW + 3 * XLEN;

    logic [W-1:0] in_bus;
    logic [W-1:0] out_bus;
    logic         reg_write_q;
    logic [1:0]   src_q;

    assign in_bus = {reg_write_m, result_src_m, rd_m,
                     pc_plus4_m, read_data_m, alu_result_m};

    pipe_skid_buf #(
        .WIDTH (W),
        .SKID  (SKID)
    ) u_buf (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_bus),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_bus)
    );

    assign {reg_write_q, src_q, rd_w,
            pc_plus4_w, read_data_w, alu_result_w} = out_bus;

    // Writes to x0 are dropped here so the regfile needs no check.
    assign reg_write_w = out_valid && reg_write_q
                         && (rd_w != '0);

    always_comb begin
        result_w = alu_result_w;
        case (src_q)
            RESULT_MEM: result_w = read_data_w;
            RESULT_PC4: result_w = pc_plus4_w;
            default:    result_w = alu_result_w;
        endcase
    end

endmodule
